// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA register-interface SPI master: FSM states,
// frame layout constants, register-map addresses and the frame builder.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int CMD_WRITE_BIT = 7;
  localparam int FRAME_BITS    = 16;

  localparam logic [2:0] STATUS = 3'd0;
  localparam logic [2:0] CTRL   = 3'd1;
  localparam logic [2:0] P      = 3'd2;
  localparam logic [2:0] E      = 3'd3;
  localparam logic [2:0] M      = 3'd4;
  localparam logic [2:0] CONST  = 3'd5;
  localparam logic [2:0] C      = 3'd6;

  // Command byte carries the zero-extended address with the write flag on top;
  // reads send an all-zero data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       write,
                                                        input logic [7:0] addr,
                                                        input logic [7:0] wdata);
    logic [7:0] cmd;
    cmd                = addr;
    cmd[CMD_WRITE_BIT] = write;
    return {cmd, (write ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// Request/response port of the SPI register master.
interface spi_reg_master_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [REG_W-1:0]  req_wdata;
  logic              rsp_valid;
  logic [REG_W-1:0]  rsp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV clocks, restartable by clr.
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == LAST);

  // divider counter, reloaded on every tick and on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || tick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end
endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing 16-bit single-register write/read frames
// (command byte then data byte) to the chip's register slave.
module spi_reg_master
  import rsa_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_reg_master_if.slave bus,
  output logic            spi_cs_n,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso
);
  localparam int CMD_W = FRAME_BITS - REG_W;

  spi_state_e            state_r, state_s;
  logic                  tick_s, load_s, rise_s, fall_s, done_s, open_s;
  logic [FRAME_BITS-1:0] frame_r;
  logic [3:0]            bit_cnt_r;
  logic [REG_W-1:0]      rx_r, rsp_rdata_r;
  logic                  cs_n_r, sclk_r, ready_r, busy_r, rsp_valid_r;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_s),
    .tick  (tick_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next state and one-cycle datapath strobes
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    done_s  = 1'b0;
    open_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid && ready_r) begin
          state_s = SETUP;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_s = SHIFT;
          rise_s  = 1'b1;
        end else begin
          state_s = SETUP;
        end
      end
      SHIFT: begin
        if (tick_s && sclk_r) begin
          fall_s  = 1'b1;
          state_s = (bit_cnt_r == 4'd0) ? HOLD : SHIFT;
        end else if (tick_s) begin
          rise_s  = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (tick_s) begin
          state_s = GAP;
          done_s  = 1'b1;
        end else begin
          state_s = HOLD;
        end
      end
      GAP: begin
        if (tick_s) begin
          state_s = IDLE;
          open_s  = 1'b1;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // MOSI is frame_r's MSB; shifting in zeros leaves the line low after bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r     <= {FRAME_BITS{1'b0}};
      bit_cnt_r   <= 4'd0;
      rx_r        <= {REG_W{1'b0}};
      rsp_rdata_r <= {REG_W{1'b0}};
      cs_n_r      <= 1'b1;
      sclk_r      <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      if (load_s) begin
        frame_r   <= build_frame(bus.req_write, CMD_W'(bus.req_addr), bus.req_wdata);
        bit_cnt_r <= 4'(FRAME_BITS - 1);
        cs_n_r    <= 1'b0;
        ready_r   <= 1'b0;
        busy_r    <= 1'b1;
      end else if (rise_s) begin
        sclk_r <= 1'b1;
        rx_r   <= {rx_r[REG_W-2:0], spi_miso};
      end else if (fall_s) begin
        sclk_r  <= 1'b0;
        frame_r <= {frame_r[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt_r != 4'd0) begin
          bit_cnt_r <= bit_cnt_r - 4'd1;
        end
      end else if (done_s) begin
        cs_n_r      <= 1'b1;
        rsp_rdata_r <= rx_r;
      end else if (open_s) begin
        ready_r <= 1'b1;
        busy_r  <= 1'b0;
      end
      rsp_valid_r <= done_s;
    end
  end

  assign spi_cs_n      = cs_n_r;
  assign spi_clk       = sclk_r;
  assign spi_mosi      = frame_r[FRAME_BITS-1];
  assign bus.req_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_spi_reg_master.sv
// Randomized bench for spi_reg_master: behavioural SPI slave plus a
// register-map reference model and frame/timing expectations.
module tb_spi_reg_master;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_reg_master_if #(.ADDR_W(3), .REG_W(8)) bus ();

  spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_seed(input int i);
    return 8'(8'h3C + (i - 6) * 43);
  endfunction

  // reference register map, updated when a request is issued
  logic [7:0] ref_mem [8];

  // monitor and slave state
  int rises = 0, fall_cyc = 0, first_rise_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  int cs_rise_cyc = 0, last_gap = 0, frames_done = 0, s_n = 0;
  logic [15:0] mosi_cap = 16'h0000, s_sh = 16'h0000;
  logic [7:0]  rsp_data = 8'h00, s_junk = 8'h00, s_data = 8'h00;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, seeded = 1'b0;
  logic [7:0]  slave_mem [8];
  logic [15:0] frame_q [$];
  int          rise_q [$];

  // line monitor + mode-0 slave: command-phase MISO is junk, data phase is mem[addr]
  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 8; i++) slave_mem[i] = mem_seed(i);
      seeded = 1'b1;
    end
    if (prev_cs && !spi_cs_n) begin
      fall_cyc = cyc; last_gap = cyc - cs_rise_cyc; rises = 0; mosi_cap = 16'h0000;
      s_n = 0; s_junk = 8'($urandom); spi_miso = s_junk[7];
    end
    if (!prev_cs && spi_cs_n) begin
      cs_rise_cyc = cyc; frame_q.push_back(mosi_cap); rise_q.push_back(rises); frames_done++;
    end
    if (!spi_cs_n && !prev_sclk && spi_clk) begin
      if (rises == 0) first_rise_cyc = cyc;
      rises++;
      mosi_cap = {mosi_cap[14:0], spi_mosi};
      s_sh = {s_sh[14:0], spi_mosi};
      s_n++;
      if (s_n == 8) s_data = slave_mem[s_sh[2:0]];
      if (s_n == 16 && s_sh[15]) slave_mem[s_sh[10:8]] = s_sh[7:0];
    end
    if (!spi_cs_n && prev_sclk && !spi_clk && s_n < 16)
      spi_miso = (s_n < 8) ? s_junk[7 - s_n] : s_data[15 - s_n];
    if (bus.rsp_valid) begin
      rsp_cyc = cyc; rsp_cnt++; rsp_data = bus.rsp_rdata;
    end
    prev_cs = spi_cs_n; prev_sclk = spi_clk;
  end

  // mode 0: plain, 1: inputs change after handshake, 2: stray req_valid at T+10
  task automatic run_frame(input logic wr, input logic [2:0] a, input logic [7:0] d, input int mode);
    int t, base_rsp, base_fr;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rd;
    exp_frame = {wr, 4'b0000, a, (wr ? d : 8'h00)};
    exp_rd    = ref_mem[a];
    if (wr) ref_mem[a] = d;
    base_rsp = rsp_cnt; base_fr = frames_done;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    for (int to = 0; to < 100 && !bus.req_ready; to++) @(negedge clk);
    if (!bus.req_ready) begin
      check_value("hs_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    t = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (mode == 1) begin
      bus.req_addr = 3'd0; bus.req_write = ~wr; bus.req_wdata = ~d;
    end
    for (int to = 0; to < 300 && rsp_cnt == base_rsp; to++) begin
      @(negedge clk);
      if (mode == 2 && cyc == t + 10) bus.req_valid = 1'b1;
      else bus.req_valid = 1'b0;
    end
    if (rsp_cnt == base_rsp) begin
      check_value("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    check_value("frame", mosi_cap, exp_frame);
    check_value("rises", rises, 16);
    check_value("cs_fall", fall_cyc, t + 1);
    check_value("first_rise", first_rise_cyc, t + 1 + D);
    check_value("rsp_cyc", rsp_cyc, t + 1 + 33 * D);
    check_value("cs_rise", cs_rise_cyc, t + 1 + 33 * D);
    check_value("rdata", rsp_data, exp_rd);
    for (int to = 0; to < 50 && !bus.req_ready; to++) @(negedge clk);
    check_value("ready_cyc", cyc, t + 1 + 34 * D);
    check_value("busy_idle", bus.busy, 1'b0);
    check_value("rdata_held", bus.rsp_rdata, exp_rd);
    check_value("rsp_count", rsp_cnt, base_rsp + 1);
    check_value("frame_count", frames_done, base_fr + 1);
  endtask

  initial begin
    int t1, t2, base_rsp;
    logic [7:0] e2;
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 3'd0; bus.req_wdata = 8'h00;
    for (int i = 0; i < 8; i++) ref_mem[i] = mem_seed(i);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_ready", bus.req_ready, 1'b1);
    check_value("rst_busy", bus.busy, 1'b0);
    check_value("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_value("rst_rdata", bus.rsp_rdata, 8'h00);
    check_value("rst_cs_n", spi_cs_n, 1'b1);
    check_value("rst_sclk", spi_clk, 1'b0);
    check_value("rst_mosi", spi_mosi, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(1'b1, 3'd2, 8'hA5, 0);
    run_frame(1'b0, 3'd6, 8'h5A, 0);
    repeat (5) @(negedge clk);
    check_value("read6_held", bus.rsp_rdata, 8'h3C);
    run_frame(1'b1, 3'd7, 8'hFF, 1);

    // two back-to-back writes with req_valid held high
    base_rsp = rsp_cnt;
    ref_mem[3] = 8'h11; e2 = ref_mem[4]; ref_mem[4] = 8'h22;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd3; bus.req_wdata = 8'h11;
    for (int to = 0; to < 100 && !bus.req_ready; to++) @(negedge clk);
    t1 = cyc;
    @(negedge clk);
    bus.req_addr = 3'd4; bus.req_wdata = 8'h22;
    t2 = 0;
    for (int to = 0; to < 100; to++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        t2 = cyc;
        break;
      end
    end
    check_value("q_ready", t2, t1 + 1 + 34 * D);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int to = 0; to < 300 && rsp_cnt < base_rsp + 2; to++) @(negedge clk);
    check_value("q_rsp_count", rsp_cnt, base_rsp + 2);
    check_value("q_cs_fall", fall_cyc, t1 + 2 + 34 * D);
    check_value("q_gap", last_gap, D + 1);
    check_value("q_frame1", frame_q[$-1], 16'h8311);
    check_value("q_frame2", frame_q[$], 16'h8422);
    check_value("q_rises1", rise_q[$-1], 16);
    check_value("q_rises2", rise_q[$], 16);
    check_value("q_rdata2", rsp_data, e2);
    for (int to = 0; to < 50 && !bus.req_ready; to++) @(negedge clk);

    run_frame(1'b1, 3'd1, 8'(($urandom)), 2);

    // reset in the middle of a read
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'd5;
    for (int to = 0; to < 100 && !bus.req_ready; to++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int to = 0; to < 200 && rises < 6; to++) @(negedge clk);
    base_rsp = rsp_cnt;
    #1 rst_n = 1'b0;
    #1;
    check_value("mid_rst_cs_n", spi_cs_n, 1'b1);
    check_value("mid_rst_sclk", spi_clk, 1'b0);
    check_value("mid_rst_mosi", spi_mosi, 1'b0);
    check_value("mid_rst_ready", bus.req_ready, 1'b1);
    check_value("mid_rst_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check_value("mid_rst_no_rsp", rsp_cnt, base_rsp);
    check_value("mid_rst_rdata", bus.rsp_rdata, 8'h00);
    run_frame(1'b0, 3'd0, 8'h00, 0);

    for (int n = 0; n < 20; n++)
      run_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI mode-0 master that issues single-register write and read frames to the chip's SPI register slave: 3-bit address, 8-bit registers, status at address 0. It is the host-side end of the register interface. It serves as an on-chip bring-up host driving the RSA register map (P, E, M, Const, C, start/stop) and as the reference initiator in the block's testbenches. Requests enter on a valid/ready port and responses leave as a one-cycle pulse.

## Interface
- ADDR_W, 3, register address width
- REG_W, 8, register data width
- CLK_DIV, 2, spi_clk half-period in clk cycles, must be ≥1
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high in IDLE, request accepted when req_valid && req_ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  target register
- req_wdata  input  REG_W  write data, ignored on read
- rsp_valid  output  1  one-cycle pulse at frame end
- rsp_rdata  output  REG_W  MISO data-phase bits, valid with rsp_valid and held until the next frame
- busy  output  1  high from acceptance until req_ready reasserts
- spi_cs_n  output  1  chip select, active low
- spi_clk  output  1  SPI clock, idle low
- spi_mosi  output  1  serial out, MSB first
- spi_miso  input  1  serial in

## Operation
- Frame is 16 bits, MSB first: an 8-bit command byte, then a REG_W data byte.
- Command byte layout:
  - bit7 = req_write.
  - bits[6:ADDR_W] = 0.
  - bits[ADDR_W-1:0] = req_addr.
- Data byte is req_wdata on a write and 0x00 on a read.
- req_write, req_addr and req_wdata are latched at the handshake. Later changes on these inputs have no effect on the frame in flight.
- MISO is captured on the clk edge that drives spi_clk 0→1. Only the 8 data-phase bits land in rsp_rdata, and this happens for both writes and reads.
- MOSI changes only on the clk edge that drives spi_clk 1→0, or at SETUP entry for bit 15.
- States:
  - IDLE: req_ready=1. Go to SETUP on handshake.
  - SETUP: cs_n=0, mosi=frame[15], hold CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 bits, each CLK_DIV cycles high then CLK_DIV cycles low. After the 16th falling edge go to HOLD.
  - HOLD: CLK_DIV cycles, then go to GAP with cs_n=1 and a rsp_valid pulse on that cycle.
  - GAP: cs_n high for CLK_DIV cycles, then go to IDLE.
- req_valid while not ready is ignored. There is no queueing and no abort input.
- Bit counter counts 15→0 and does not wrap. Divider counter reloads every half-period.

## Timing
- Handshake at cycle T. All offsets below are in clk cycles with D = CLK_DIV.
- spi_cs_n falls at T+1. mosi carries command bit7 from T+1.
- Rising edge of bit k (k = 0..15, from MSB) occurs at T+1+D+2Dk. The last falling edge occurs at T+1+32D.
- spi_cs_n rises and rsp_valid pulses at T+1+33D.
- req_ready reasserts at T+1+34D. The earliest next handshake is that cycle.
- With D=2: cs_n low at T+1, first rise at T+3, cs_n high and rsp_valid at T+67, ready at T+69.
- busy = !req_ready.
- Reset values:
  - req_ready=1, busy=0
  - rsp_valid=0, rsp_rdata=0
  - spi_cs_n=1, spi_clk=0, spi_mosi=0
  - state=IDLE
- Reset mid-frame: all outputs return to their reset values asynchronously. No rsp_valid is produced and the partial frame is discarded. The first request after reset release behaves as normal.
- A handshake on the same cycle as GAP→IDLE is not possible, because ready is registered. The handshake happens on the first IDLE cycle.

## Structure
- Shared package rsa_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP)
  - CMD_WRITE_BIT=7
  - FRAME_BITS=16
  - the register-map address constants: STATUS=0, CTRL=1, P=2, E=3, M=4, CONST=5, C=6
- One sub-module, spi_tick_gen: a half-period divider producing a one-cycle tick every CLK_DIV cycles. It is cleared at the handshake.
- The shift register, bit counter and FSM stay in the top module.

## Test plan
- Write addr 2, data 0xA5, D=2 → MOSI frame 0x82A5 sampled on 16 rising edges, cs_n low T+1..T+66, rsp_valid at T+67, req_ready at T+69.
- Read addr 6 with the slave model returning 0x3C → MOSI frame 0x0600, rsp_rdata=0x3C with rsp_valid, value held afterwards.
- Write addr 7, data 0xFF, with req_addr changed to 0 one cycle after handshake → command byte 0x87, frame unaffected.
- req_valid held high with two queued writes → second cs_n fall at T+70, exactly 16 spi_clk rises per frame, cs_n high ≥2 cycles between frames.
- req_valid pulsed at T+10 during a frame → ignored, no second frame, one rsp_valid.
- rst_n low at bit 5 of a read → cs_n=1, spi_clk=0, mosi=0 immediately, no rsp_valid. A following read of addr 0 completes normally.
